// File: rtl/sar_pkg.sv
// sar_pkg: shared types and constants for the successive-approximation search engine.
package sar_pkg;
  localparam int SAR_WIDTH = 10;
  localparam int SAR_IDX_W = $clog2(SAR_WIDTH);
  typedef enum logic [1:0] {IDLE, TEST, VERIFY} state_t;
  function automatic logic one_hot3(input logic [2:0] f);
    return f == 3'b001 || f == 3'b010 || f == 3'b100;
  endfunction
endpackage

// File: rtl/sar_search_10_step.sv
// sar_step: next trial value for one successive-approximation bit decision.
module sar_step #(
  parameter int WIDTH = 10,
  parameter int IW = 4
) (
  input  logic [WIDTH-1:0] trial,
  input  logic [IW-1:0]    idx,
  input  logic             cmp_gr,
  output logic [WIDTH-1:0] next_trial
);
  logic [WIDTH-1:0] bit_m;
  assign bit_m = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
  // bit_m >> 1 is zero at idx 0, so the last step sets no lower bit
  assign next_trial = (cmp_gr ? trial & ~bit_m : trial) | (bit_m >> 1);
endmodule

// File: rtl/sar_search_10.sv
// sar_search_10: MSB-first SAR search against an external comparator.
// Optional SAR_EARLY_EXIT_EN ends the search on the first clean equality in TEST.
module sar_search_10
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_ls,
  input  logic             cmp_gr,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] next_trial;
  logic clean;
  assign clean = one_hot3({cmp_eq, cmp_ls, cmp_gr});
  sar_step #(.WIDTH(WIDTH), .IW(IW)) u_step (
    .trial(trial),
    .idx(idx),
    .cmp_gr(cmp_gr),
    .next_trial(next_trial)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      trial <= '0;
      result <= '0;
      found <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            trial <= MSB;
            idx <= IW'(WIDTH-1);
            busy <= 1'b1;
            err <= 1'b0;
            found <= 1'b0;
            state <= TEST;
          end else begin
            trial <= '0;
          end
        end
        TEST: begin
          if (!clean) err <= 1'b1;
`ifdef SAR_EARLY_EXIT_EN
          if (clean && cmp_eq) begin
            result <= trial;
            found <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            trial <= '0;
            state <= IDLE;
          end else begin
            trial <= next_trial;
            if (idx == '0) state <= VERIFY;
            else idx <= idx - 1'b1;
          end
`else
          trial <= next_trial;
          if (idx == '0) state <= VERIFY;
          else idx <= idx - 1'b1;
`endif
        end
        VERIFY: begin
          if (!clean) err <= 1'b1;
          found <= cmp_eq;
          result <= trial;
          done <= 1'b1;
          busy <= 1'b0;
          trial <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_search_10.sv
// tb_sar_search_10: directed self-checking bench with a behavioural 10-bit comparator.
module tb_sar_search_10;
  logic clk = 1'b0;
  logic rst, start, cmp_eq, cmp_ls, cmp_gr, busy, done, found, err, fault;
  logic [9:0] trial, result, target;
  int n_chk = 0;
  int n_fail = 0;
  int lat, bcnt;
  always #5 clk = ~clk;
  assign cmp_eq = (trial == target) | fault;
  assign cmp_ls = trial < target;
  assign cmp_gr = (trial > target) | fault;
  sar_search_10 dut (
    .clk(clk), .rst(rst), .start(start), .cmp_eq(cmp_eq), .cmp_ls(cmp_ls), .cmp_gr(cmp_gr),
    .trial(trial), .busy(busy), .done(done), .result(result), .found(found), .err(err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // after E0 the loop ticks until done; lat counts edges from E0, bcnt counts busy cycles
  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (!done && l < 40) begin
      b += int'(busy);
      tick();
      l++;
    end
    chk("done_within_bound", int'(done), 1);
  endtask
  task automatic search(input logic [9:0] tgt, output int l, output int b);
    target = tgt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(l, b);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    fault = 1'b0;
    target = '0;
    tick();
    tick();
    chk("rst_trial", int'(trial), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({busy, done, found, err}), 0);
    rst = 1'b0;
    tick();
    chk("idle_trial", int'(trial), 0);
    // target 0: every bit decision clears the tested bit
    target = 10'h000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t0_busy_e0", int'(busy), 1);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("t0_trial_%0d", k), int'(trial), (k < 10) ? (32'h200 >> k) : 0);
      chk($sformatf("t0_nodone_%0d", k), int'(done), 0);
      tick();
    end
    chk("t0_done", int'(done), 1);
    chk("t0_busy_end", int'(busy), 0);
    chk("t0_result", int'(result), 'h000);
    chk("t0_found", int'(found), 1);
    chk("t0_err", int'(err), 0);
    tick();
    chk("t0_done_pulse", int'(done), 0);
    chk("t0_result_hold", int'(result), 'h000);
    search(10'h3FF, lat, bcnt);
    chk("t3ff_result", int'(result), 'h3FF);
    chk("t3ff_found", int'(found), 1);
    search(10'h155, lat, bcnt);
    chk("t155_result", int'(result), 'h155);
    chk("t155_found", int'(found), 1);
`ifdef SAR_EARLY_EXIT_EN
    chk("t155_lat", lat, 10);
    search(10'h200, lat, bcnt);
    chk("t200_lat", lat, 1);
`else
    chk("t155_lat", lat, 11);
    chk("t155_busy_cycles", bcnt, 11);
    search(10'h200, lat, bcnt);
    chk("t200_lat", lat, 11);
`endif
    chk("t200_result", int'(result), 'h200);
    chk("t200_found", int'(found), 1);
    // eq and gr forced together while bit 5 is tested: bit 5 is dropped, err latches
    target = 10'h0AA;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("flt_trial_b5", int'(trial), 'h0A0);
    fault = 1'b1;
    tick();
    fault = 1'b0;
    chk("flt_err_now", int'(err), 1);
    wait_done(lat, bcnt);
    chk("flt_result", int'(result), 'h09F);
    chk("flt_found", int'(found), 0);
    chk("flt_err_done", int'(err), 1);
    tick();
    chk("flt_err_hold", int'(err), 1);
    search(10'h0AA, lat, bcnt);
    chk("clean_err", int'(err), 0);
    chk("clean_result", int'(result), 'h0AA);
    // reset during the fifth cycle of a search
    target = 10'h155;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_trial", int'(trial), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_flags", int'({busy, done, found, err}), 0);
    tick();
    chk("mid_rst_idle", int'({busy, trial}), 0);
    search(10'h0AA, lat, bcnt);
    chk("post_rst_result", int'(result), 'h0AA);
    chk("post_rst_found", int'(found), 1);
    // start held high for the whole search: ignored while busy, re-accepted on done
    target = 10'h155;
    start = 1'b1;
    tick();
    tick();
    tick();
    chk("held_trial_e2", int'(trial), 'h180);
    chk("held_busy", int'(busy), 1);
    lat = 2;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("held_done", int'(done), 1);
    chk("held_result", int'(result), 'h155);
    tick();
    start = 1'b0;
    chk("held_reaccept_busy", int'(busy), 1);
    chk("held_reaccept_trial", int'(trial), 'h200);
    chk("held_reaccept_nodone", int'(done), 0);
    wait_done(lat, bcnt);
    chk("held_second_result", int'(result), 'h155);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
